// File: rtl/song_pkg.sv
// Shared types and built-in melody data for the song sequencer and its ROM.
package song_pkg;

  localparam int SONG_NOTE_W = 4;
  localparam int SONG_DUR_W  = 27;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } song_state_e;

  typedef struct packed {
    logic [SONG_NOTE_W-1:0] note;
    logic [SONG_DUR_W-1:0]  dur;
  } song_entry_t;

  function automatic song_entry_t mk_entry(input int n, input int d);
    song_entry_t e;
    e.note = SONG_NOTE_W'(n);
    e.dur  = SONG_DUR_W'(d);
    return e;
  endfunction

  // Song table; an entry with dur 0 terminates a song early.
  function automatic song_entry_t song_data(input int song, input int idx);
    song_entry_t e;
    e = mk_entry(0, 0);
    case (song)
      0: begin
        case (idx)
          0:       e = mk_entry(2, 10);
          1:       e = mk_entry(3, 4);
          default: e = mk_entry(0, 0);
        endcase
      end
      1:       e = mk_entry((idx % 15) + 1, 4);
      2:       e = mk_entry(15 - (idx % 16), 2);
      3: begin
        case (idx)
          0:       e = mk_entry(5, 3);
          1:       e = mk_entry(5, 3);
          2:       e = mk_entry(7, 6);
          default: e = mk_entry(0, 0);
        endcase
      end
      default: e = mk_entry(0, 0);
    endcase
    return e;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song storage: NUM_SONGS x DEPTH {note,dur} entries, synchronous read with one cycle latency.
module song_rom
  import song_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int DEPTH     = 32,
  parameter int NOTE_W    = SONG_NOTE_W,
  parameter int DUR_W     = SONG_DUR_W,
  parameter int SONG_W    = 2,
  parameter int ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic [SONG_W+ADDR_W-1:0] i_addr,
  output logic [NOTE_W-1:0]        o_note,
  output logic [DUR_W-1:0]         o_dur
);

  localparam int ENTRIES = 2 ** (SONG_W + ADDR_W);

  song_entry_t       w_mem [ENTRIES];
  logic [NOTE_W-1:0] r_note;
  logic [DUR_W-1:0]  r_dur;

  // Address is {song,location}; slots beyond the stored songs read as terminators.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_init
    assign w_mem[gi] = ((gi / (2 ** ADDR_W)) < NUM_SONGS && (gi % (2 ** ADDR_W)) < DEPTH)
                       ? song_data(gi / (2 ** ADDR_W), gi % (2 ** ADDR_W))
                       : mk_entry(0, 0);
  end

  always_ff @(posedge clk) begin
    r_note <= NOTE_W'(w_mem[i_addr].note);
    r_dur  <= DUR_W'(w_mem[i_addr].dur);
  end

  assign o_note = r_note;
  assign o_dur  = r_dur;

endmodule

// File: rtl/song_sequencer.sv
// Melody playback engine: walks the selected song, holding each note for its duration.
// Optional SONG_GAP_EN inserts a silent GAP_CYCLES gap after every non-final note.
module song_sequencer
  import song_pkg::*;
#(
  parameter int  NUM_SONGS  = 4,
  parameter int  DEPTH      = 32,
  parameter int  NOTE_W     = SONG_NOTE_W,
  parameter int  DUR_W      = SONG_DUR_W,
  parameter int  GAP_CYCLES = 5_000_000,
  localparam int SONG_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SONG_W-1:0] song_sel,
  input  logic              pause,
  input  logic              stop,
  output logic [NOTE_W-1:0] note,
  output logic              note_on,
  output logic [ADDR_W-1:0] location,
  output logic              busy,
  output logic              done,
  output logic              song_err
);

  localparam logic [SONG_W:0]   SEL_LIMIT = (SONG_W + 1)'(NUM_SONGS);
  localparam logic [ADDR_W-1:0] LAST_LOC  = ADDR_W'(DEPTH - 1);
  localparam logic [DUR_W-1:0]  GAP_LOAD  = DUR_W'(GAP_CYCLES - 1);

  song_state_e       r_state, w_state_nx;
  logic [SONG_W-1:0] r_sel, w_sel_nx;
  logic [ADDR_W-1:0] r_loc, w_loc_nx;
  logic [NOTE_W-1:0] r_note, w_note_nx;
  logic              r_err, w_err_nx;
  logic [DUR_W-1:0]  r_cnt, w_cnt_nx;
  logic [NOTE_W-1:0] w_rom_note;
  logic [DUR_W-1:0]  w_rom_dur;
  logic              w_sel_ok;
  logic              w_note_on, w_busy, w_done;

  song_rom #(
    .NUM_SONGS(NUM_SONGS),
    .DEPTH    (DEPTH),
    .NOTE_W   (NOTE_W),
    .DUR_W    (DUR_W),
    .SONG_W   (SONG_W),
    .ADDR_W   (ADDR_W)
  ) u_rom (
    .clk   (clk),
    .i_addr({r_sel, r_loc}),
    .o_note(w_rom_note),
    .o_dur (w_rom_dur)
  );

  assign w_sel_ok = ({1'b0, song_sel} < SEL_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_loc_nx   = r_loc;
    w_note_nx  = r_note;
    w_err_nx   = 1'b0;
    w_cnt_nx   = r_cnt;
    w_note_on  = 1'b0;
    w_busy     = (r_state != S_IDLE);
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (w_sel_ok) begin
            w_sel_nx   = song_sel;
            w_loc_nx   = '0;
            w_state_nx = S_FETCH;
          end else begin
            w_err_nx = 1'b1;
          end
        end
      end
      S_FETCH: w_state_nx = S_LOAD;
      S_LOAD: begin
        if (w_rom_dur == '0) begin
          w_state_nx = S_DONE;
        end else begin
          w_note_nx  = w_rom_note;
          w_cnt_nx   = w_rom_dur - DUR_W'(1);
          w_state_nx = S_PLAY;
        end
      end
      S_PLAY: begin
        w_note_on = !pause;
        if (!pause) begin
          if (r_cnt == '0) begin
            // Preloading the gap length here is harmless when no GAP state follows.
            w_cnt_nx = GAP_LOAD;
            if (r_loc == LAST_LOC) begin
              w_state_nx = S_DONE;
            end else begin
              w_loc_nx = r_loc + ADDR_W'(1);
`ifdef SONG_GAP_EN
              w_state_nx = S_GAP;
`else
              w_state_nx = S_FETCH;
`endif
            end
          end else begin
            w_cnt_nx = r_cnt - DUR_W'(1);
          end
        end
      end
`ifdef SONG_GAP_EN
      S_GAP: begin
        if (!pause) begin
          if (r_cnt == '0) w_state_nx = S_FETCH;
          else             w_cnt_nx   = r_cnt - DUR_W'(1);
        end
      end
`endif
      S_DONE: begin
        w_done     = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (stop && (r_state != S_IDLE)) begin
      w_state_nx = S_IDLE;
      w_loc_nx   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel  <= '0;
      r_loc  <= '0;
      r_note <= '0;
      r_err  <= 1'b0;
    end else begin
      r_sel  <= w_sel_nx;
      r_loc  <= w_loc_nx;
      r_note <= w_note_nx;
      r_err  <= w_err_nx;
    end
  end

  always_ff @(posedge clk) begin
    r_cnt <= w_cnt_nx;
  end

  assign note     = r_note;
  assign note_on  = w_note_on;
  assign location = r_loc;
  assign busy     = w_busy;
  assign done     = w_done;
  assign song_err = r_err;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer (NUM_SONGS=3, DEPTH=8); timing expectations follow SONG_GAP_EN.
module tb_song_sequencer;

  localparam int NS = 3;
  localparam int DP = 8;
  localparam int NW = 4;
  localparam int DW = 27;
  localparam int GC = 3;
  localparam int SW = 2;
  localparam int AW = 3;
`ifdef SONG_GAP_EN
  localparam int G = GC;
`else
  localparam int G = 0;
`endif
  localparam int P1 = 6 + G;
  localparam int P2 = 4 + G;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] song_sel = '0;
  logic          pause = 1'b0;
  logic          stop = 1'b0;
  logic [NW-1:0] note;
  logic          note_on;
  logic [AW-1:0] location;
  logic          busy;
  logic          done;
  logic          song_err;

  int errors = 0;
  int checks = 0;

  logic [63:0]   m_on, m_done, m_busy, m_err, m_exp;
  logic [NW-1:0] a_note [64];
  logic [AW-1:0] a_loc  [64];
  int            xc;

  song_sequencer #(
    .NUM_SONGS (NS),
    .DEPTH     (DP),
    .NOTE_W    (NW),
    .DUR_W     (DW),
    .GAP_CYCLES(GC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .song_sel(song_sel),
    .pause   (pause),
    .stop    (stop),
    .note    (note),
    .note_on (note_on),
    .location(location),
    .busy    (busy),
    .done    (done),
    .song_err(song_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic clr();
    m_on = '0; m_done = '0; m_busy = '0; m_err = '0;
    for (int i = 0; i < 64; i++) begin
      a_note[i] = '0;
      a_loc[i]  = '0;
    end
  endtask

  task automatic rec(input int c);
    m_on[c]   = note_on;
    m_done[c] = done;
    m_busy[c] = busy;
    m_err[c]  = song_err;
    a_note[c] = note;
    a_loc[c]  = location;
  endtask

  // Begins cycle 0 with a start request for the given song.
  task automatic begin_song(input logic [SW-1:0] sel);
    @(posedge clk); #1;
    start = 1'b1; song_sel = sel; pause = 1'b0; stop = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_note", 64'(note), 64'd0);
    check("rst_note_on", 64'(note_on), 64'd0);
    check("rst_location", 64'(location), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_song_err", 64'(song_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Song 0: {2,10},{3,4},terminator
    clr();
    begin_song(2'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      rec(c);
    end
    check("s0_note_on_mask", m_on, rng(3, 12) | rng(15 + G, 18 + G));
    check("s0_done_mask", m_done, rng(21 + 2 * G, 21 + 2 * G));
    check("s0_busy_mask", m_busy, rng(1, 21 + 2 * G));
    check("s0_note_first", 64'(a_note[5]), 64'd2);
    check("s0_note_second", 64'(a_note[16 + G]), 64'd3);
    check("s0_loc_second", 64'(a_loc[16 + G]), 64'd1);
    check("s0_note_held_after_done", 64'(a_note[22 + 2 * G]), 64'd3);

    // Pause for 5 cycles in the middle of the 10-cycle note
    clr();
    begin_song(2'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      pause = (c >= 6 && c <= 10);
      #1;
      rec(c);
    end
    pause = 1'b0;
    check("pause_note_on_mask", m_on, rng(3, 5) | rng(11, 17) | rng(20 + G, 23 + G));
    check("pause_done_mask", m_done, rng(26 + 2 * G, 26 + 2 * G));
    check("pause_note_after", 64'(a_note[11]), 64'd2);

    // Start while busy ignored; stop during the second note
    clr();
    begin_song(2'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start    = (c == 5);
      song_sel = (c == 5) ? 2'd1 : 2'd0;
      stop     = (c == 16 + G);
      #1;
      rec(c);
    end
    stop = 1'b0;
    check("stop_note_on_mask", m_on, rng(3, 12) | rng(15 + G, 16 + G));
    check("stop_busy_mask", m_busy, rng(1, 16 + G));
    check("stop_done_mask", m_done, 64'd0);
    check("stop_loc_after", 64'(a_loc[17 + G]), 64'd0);
    check("stop_note_second", 64'(a_note[16 + G]), 64'd3);

    // Out-of-range song select
    clr();
    begin_song(2'd3);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      rec(c);
    end
    check("err_pulse_mask", m_err, rng(1, 1));
    check("err_busy_mask", m_busy, 64'd0);

    // Song 2 has no terminator: plays all DEPTH entries
    clr();
    begin_song(2'd2);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      rec(c);
    end
    m_exp = '0;
    for (int k = 0; k < DP; k++) m_exp = m_exp | rng(3 + P2 * k, 4 + P2 * k);
    check("full_note_on_mask", m_on, m_exp);
    check("full_done_mask", m_done, rng(5 + 7 * P2, 5 + 7 * P2));
    check("full_busy_mask", m_busy, rng(1, 5 + 7 * P2));
    check("full_note_first", 64'(a_note[3]), 64'd15);
    check("full_loc_second", 64'(a_loc[3 + P2]), 64'd1);
    check("full_note_last", 64'(a_note[4 + 7 * P2]), 64'd8);
    check("full_loc_last", 64'(a_loc[4 + 7 * P2]), 64'd7);

    // Reset in the middle of song 1, location 5
    clr();
    xc = 3 + 5 * P1 + 1;
    begin_song(2'd1);
    for (int c = 1; c <= xc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      rec(c);
    end
    check("mid_loc", 64'(a_loc[xc]), 64'd5);
    check("mid_note", 64'(a_note[xc]), 64'd6);
    check("mid_note_on", 64'(m_on[xc]), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_note", 64'(note), 64'd0);
    check("arst_note_on", 64'(note_on), 64'd0);
    check("arst_location", 64'(location), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_song_err", 64'(song_err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clr();
    begin_song(2'd1);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      rec(c);
    end
    check("restart_note_on_mask", m_on, rng(3, 5));
    check("restart_loc", 64'(a_loc[3]), 64'd0);
    check("restart_note", 64'(a_note[3]), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
